// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: start/busy/done bundle for the BCD-to-binary converter.
// The error signal exists only when BCD_CHECK_EN is defined.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
`ifdef BCD_CHECK_EN
    logic                  error;
    modport master (output start, bcd_in, input busy, done, bin_out, error);
    modport slave  (input start, bcd_in, output busy, done, bin_out, error);
`else
    modport master (output start, bcd_in, input busy, done, bin_out);
    modport slave  (input start, bcd_in, output busy, done, bin_out);
`endif
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: packed BCD to binary via reverse double dabble, one shift per clock.
// BCD_CHECK_EN adds an error flag and rejects requests carrying digits above 9.
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int CNT_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    bcd_to_binary_seq_if.slave        bus
);
    localparam int RW = 4*DIGITS + BIN_W;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      r_q, r_d, sh, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               done_q, done_d;
`ifdef BCD_CHECK_EN
    logic               error_q, error_d, rej_q, rej_d, bad;
`endif

    always_comb begin
        sh  = r_q >> 1;
        adj = sh;
        for (int i = 0; i < DIGITS; i++)
            if (sh[BIN_W+4*i +: 4] >= 4'd8) adj[BIN_W+4*i +: 4] = sh[BIN_W+4*i +: 4] - 4'd3;
    end

`ifdef BCD_CHECK_EN
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        done_d    = 1'b0;
`ifdef BCD_CHECK_EN
        error_d   = error_q;
        rej_d     = rej_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
`ifdef BCD_CHECK_EN
                rej_d = bad;
                if (bad) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d     = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
`else
                r_d     = {bus.bcd_in, {BIN_W{1'b0}}};
                cnt_d   = '0;
                state_d = SHIFT;
`endif
            end
            SHIFT: begin
                r_d     = adj;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(BIN_W-1)) ? DONE : SHIFT;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BCD_CHECK_EN
                // a rejected request pulses done but leaves the last good result in place
                if (!rej_q) begin
                    bin_out_d = r_q[BIN_W-1:0];
                    error_d   = 1'b0;
                end
`else
                bin_out_d = r_q[BIN_W-1:0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            r_q       <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            done_q    <= 1'b0;
`ifdef BCD_CHECK_EN
            error_q   <= 1'b0;
            rej_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
`ifdef BCD_CHECK_EN
            error_q   <= error_d;
            rej_q     <= rej_d;
`endif
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.bin_out = bin_out_q;
`ifdef BCD_CHECK_EN
    assign bus.error   = error_q;
`endif
endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential packed-BCD to unsigned-binary converter using reverse double dabble: shift right, then subtract 3 from each digit that is 8 or more.
- Inverse of the score/display binary-to-BCD path. Converts DIGITS BCD digits (for example, a score or a setting entered on the panel) into a binary value for arithmetic and compare logic.
- Performs one shift per clock and uses a start/busy/done handshake.

Parameters:
- DIGITS, 4, number of BCD digits; input width is 4*DIGITS.
- BIN_W, 14, binary output width; must satisfy 2^BIN_W > 10^DIGITS-1 (14 bits holds 9999).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > BIN_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request; samples bcd_in.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- busy  output  1  high while a conversion is running.
- done  output  1  one-cycle pulse when bin_out is updated.
- bin_out  output  BIN_W  converted value; held until the next conversion completes.
- error  output  1  invalid-digit flag; present only with BCD_CHECK_EN.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, busy=0, done=0, bin_out=0, error=0, working register and counter cleared. Reset wins over every other input in the same cycle.
- Working register R, width 4*DIGITS+BIN_W, laid out as {bcd field, bin field}.
- IDLE:
  - busy=0, done=0.
  - If start=1: load R={bcd_in, BIN_W'b0}, clear the counter, go to SHIFT.
  - busy is 1 from the next cycle.
- SHIFT, one iteration per cycle:
  - Logical right-shift R by 1, zero-filling the MSB.
  - Then, for every 4-bit digit of the shifted bcd field: if digit >= 8, digit = digit - 3 (4-bit, no borrow into the neighbour digit).
  - Both steps are combinational within the same cycle.
  - Counter increments; after BIN_W iterations go to DONE.
- DONE:
  - bin_out = R[BIN_W-1:0], done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency:
  - start sampled at edge N; done=1 and bin_out valid in the cycle following edge N+BIN_W+1 (BIN_W+1 cycles of busy/done activity; 15 for the defaults).
  - Back-to-back requests: the next start is accepted in the IDLE cycle after DONE.
- start while busy=1 or in DONE: ignored, not queued; bcd_in changes during a conversion have no effect.
- After BIN_W iterations the bcd field is zero for valid input.
- bin_out never changes except in DONE or on reset.

Optional Feature:
- Macro BCD_CHECK_EN.
- Defined:
  - On the start capture, any digit of bcd_in > 9 sets error=1 and the request is rejected: no SHIFT, bin_out unchanged, done pulses one cycle later.
  - A valid conversion clears error in DONE.
  - Reset clears error.
- Not defined:
  - No error port; error logic is absent.
  - Invalid digits are converted by the same algorithm; the result is deterministic but has no specified meaning.

Test Plan:
- reset=0 two cycles, then release -> busy=0, done=0, bin_out=0; start pulse with bcd_in=16'h0000 -> done after 15 cycles, bin_out=0.
- start, bcd_in=16'h1234 -> busy high 14 cycles, done one-cycle pulse, bin_out=14'd1234 (0x04D2).
- start, bcd_in=16'h9999 -> bin_out=0x270F; then bcd_in=16'h0001 on the cycle after done -> bin_out=1.
- start with 16'h0500, then start with 16'h0777 while busy, bcd_in changed mid-run -> bin_out=500 only, one done pulse.
- start with 16'h4321, reset=0 at iteration 7 -> busy=0, bin_out=0, no done; a following start with 16'h4321 -> 4321.
- BCD_CHECK_EN: bcd_in=16'h12A4 -> error=1, done pulses, bin_out keeps its previous value (1234); next start with 16'h0042 -> error=0, bin_out=42.
